alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, registered successor to the combinational 16-bit ALU.
- Adds WIDTH generalisation and a persistent flag register (C, L, F, Z, N) that feeds carry-in to ADDC/SUBC.
- Adds a valid/ready handshake on both sides and an iterative multi-cycle multiplier.
- Sits between the register file/decoder and the writeback stage of the CPU datapath.

Parameters:
- WIDTH, 16, operand/result width in bits (>= 4, power of 2).
- SHAMT_W, $clog2(WIDTH), localparam: number of shift-amount bits taken from r2.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept an operation.
- opcode  in  8  operation select.
- r1  in  WIDTH  operand A.
- r2  in  WIDTH  operand B / shift amount.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- rout  out  WIDTH  result (low half for MUL).
- rout_hi  out  WIDTH  MUL high half; 0 for all other ops.
- flags  out  5  {C,L,F,Z,N}; bit 4 = C.
- err  out  1  illegal opcode; qualified by out_valid.

Behaviour:
- Reset (reset==0 at a clock edge): state=IDLE; rout, rout_hi, flags, err = 0; out_valid=0; in_ready=0 while reset is low. Reset aborts any operation in progress, including mid-MUL.
- States:
  - IDLE: in_ready=1. on in_valid, latch opcode/r1/r2. MUL → BUSY; all other ops → DONE with result registered on the same edge.
  - BUSY: shift-add, one bit per cycle, WIDTH cycles. in_ready=0. then → DONE.
  - DONE: out_valid=1; rout/rout_hi/flags/err held stable until out_ready=1 → IDLE. in_ready=0; no accept in the same cycle as drain.
- Latency, measured as accept edge → out_valid high: 1 cycle for single-cycle ops; WIDTH+1 cycles for MUL.
- Opcodes (hex):
  - 01 AND, 02 OR, 03 XOR, 04 NOT (~r1).
  - 05 ADD, 06 ADDU, 07 ADDC (r1+r2+C).
  - 08 RSH logical, 09 SUB, 0A SUBC (r1-r2-C), 0B CMP.
  - 0C ALSH, 0D LSH, 0E MUL (unsigned, 2*WIDTH-bit product), 0F ARSH.
- Flags:
  - C = unsigned carry-out for add ops; borrow for sub ops.
  - F = signed overflow.
  - Z = result==0.
  - N = result MSB, except CMP where N = signed(r1)<signed(r2).
  - L = unsigned r1<r2; updated by CMP only.
- Flag updates per op:
  - ADD/ADDC/SUB/SUBC update C, F, Z, N.
  - ADDU updates C and Z only.
  - Logic ops and shifts update Z and N; ALSH also sets F if the sign bit changes at any step.
  - MUL updates Z (full product==0) and C (rout_hi!=0).
  - CMP updates L, N, Z and sets rout=0.
- Flags not listed for an op keep their prior value.
- Shifts: amount = r2[SHAMT_W-1:0] if r2 < WIDTH. If r2 >= WIDTH: LSH/ALSH/RSH → 0; ARSH → all bits equal r1 MSB.
- Illegal opcode: rout=0, rout_hi=0, flags unchanged, err=1, 1-cycle latency.
- Arithmetic is modulo 2^WIDTH. The carry-in C is the flag value at the accept edge.

Optional Feature:
- Macro: ALU_MUL_EN.
- Defined: MUL (0E) is implemented as above.
- Undefined: multiplier logic and the BUSY state are omitted; 0E is treated as an illegal opcode (err=1, 1-cycle latency); rout_hi is tied to 0.

Test Plan:
- ADD r1=0x7FFF, r2=0x0001 → rout=0x8000; F=1, N=1, C=0, Z=0; out_valid 1 cycle after accept.
- ADD r1=0xFFFF, r2=0x0001 → rout=0x0000, C=1, Z=1. Then ADDC r1=1, r2=1 → rout=0x0003, C=0.
- SUB 1-2 → rout=0xFFFF, C=1, N=1. Then CMP r1=0xFFFF, r2=0x0002 → rout=0, L=0, N=1, Z=0.
- ARSH r1=0x8000, r2=20 → 0xFFFF. LSH r1=1, r2=15 → 0x8000. RSH r1=0x8000, r2=16 → 0x0000.
- MUL 300*300 (ALU_MUL_EN defined) → rout=0x5F90, rout_hi=0x0001, C=1. out_valid at accept+17 cycles. Hold out_ready=0 for 5 cycles → outputs stable, in_ready=0.
- MUL accepted, then reset=0 at cycle 8 → next edge: out_valid=0, flags=0. Opcode 0x55 → err=1, rout=0.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: registered, parametrised ALU with a persistent {C,L,F,Z,N} flag
// register and valid/ready handshakes on both sides.
// Optional build macro ALU_MUL_EN: when defined, opcode 0E is an iterative
// shift-add unsigned multiplier (WIDTH+1 cycle latency) using a BUSY state;
// when undefined, 0E is an illegal opcode and rout_hi is tied to zero.
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       opcode,
    input  logic [WIDTH-1:0] r1,
    input  logic [WIDTH-1:0] r2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] rout,
    output logic [WIDTH-1:0] rout_hi,
    output logic [4:0]       flags,
    output logic             err
);

    localparam int SHAMT_W = $clog2(WIDTH);
    localparam int MSB     = WIDTH - 1;

    // Flag bit positions within {C,L,F,Z,N}
    localparam int FC = 4;
    localparam int FL = 3;
    localparam int FF = 2;
    localparam int FZ = 1;
    localparam int FN = 0;

    localparam logic [7:0] OP_AND  = 8'h01;
    localparam logic [7:0] OP_OR   = 8'h02;
    localparam logic [7:0] OP_XOR  = 8'h03;
    localparam logic [7:0] OP_NOT  = 8'h04;
    localparam logic [7:0] OP_ADD  = 8'h05;
    localparam logic [7:0] OP_ADDU = 8'h06;
    localparam logic [7:0] OP_ADDC = 8'h07;
    localparam logic [7:0] OP_RSH  = 8'h08;
    localparam logic [7:0] OP_SUB  = 8'h09;
    localparam logic [7:0] OP_SUBC = 8'h0A;
    localparam logic [7:0] OP_CMP  = 8'h0B;
    localparam logic [7:0] OP_ALSH = 8'h0C;
    localparam logic [7:0] OP_LSH  = 8'h0D;
`ifdef ALU_MUL_EN
    localparam logic [7:0] OP_MUL  = 8'h0E;
`endif
    localparam logic [7:0] OP_ARSH = 8'h0F;

`ifdef ALU_MUL_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DONE = 2'd2
    } state_t;
`endif

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_rout;
    logic [4:0]       r_flags;
    logic             r_err;

    logic             w_accept;
    logic [WIDTH-1:0] w_res;
    logic [4:0]       w_flg;
    logic             w_err;
    logic             w_upd_zn;
    logic             w_cin;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_dif;
    logic             w_big;
    logic [SHAMT_W-1:0] w_amt;
    logic [WIDTH-1:0] w_alsh_mask;
    logic             w_alsh_f;

`ifdef ALU_MUL_EN
    localparam int CNT_W = SHAMT_W + 1;
    logic             w_is_mul;
    logic [WIDTH-1:0] r_rout_hi;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_ph;
    logic [WIDTH-1:0] r_pl;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH:0]   w_step;
    logic             w_mul_last;
`endif

    assign w_accept  = in_valid && in_ready;
    assign in_ready  = (r_state == S_IDLE) && reset;
    assign out_valid = (r_state == S_DONE);
    assign rout      = r_rout;
    assign flags     = r_flags;
    assign err       = r_err;

`ifdef ALU_MUL_EN
    assign rout_hi    = r_rout_hi;
    // Partial product: high half accumulates, low half holds the unconsumed
    // multiplier bits; both shift right one place per step.
    assign w_step     = {1'b0, r_ph} + (r_pl[0] ? {1'b0, r_mcand} : '0);
    assign w_mul_last = (r_cnt == CNT_W'(WIDTH));
`else
    assign rout_hi    = '0;
`endif

    // Single-cycle result and next flag value, computed from the live inputs
    always_comb begin
        w_res    = '0;
        w_flg    = r_flags;
        w_err    = 1'b0;
        w_upd_zn = 1'b0;
`ifdef ALU_MUL_EN
        w_is_mul = 1'b0;
`endif
        w_cin = ((opcode == OP_ADDC) || (opcode == OP_SUBC)) ? r_flags[FC] : 1'b0;
        w_sum = {1'b0, r1} + {1'b0, r2} + {{WIDTH{1'b0}}, w_cin};
        w_dif = {1'b0, r1} - {1'b0, r2} - {{WIDTH{1'b0}}, w_cin};
        w_big = |(r2 >> SHAMT_W);
        w_amt = r2[SHAMT_W-1:0];
        // ALSH changes sign at some step iff any adjacent pair among the bits
        // shifted through the MSB differs; shifting >= WIDTH sweeps every bit.
        w_alsh_mask = w_big ? '1 : ~({WIDTH{1'b1}} >> w_amt);
        w_alsh_f    = |((r1 ^ {r1[WIDTH-2:0], 1'b0}) & w_alsh_mask);

        case (opcode)
            OP_AND: begin w_res = r1 & r2; w_upd_zn = 1'b1; end
            OP_OR:  begin w_res = r1 | r2; w_upd_zn = 1'b1; end
            OP_XOR: begin w_res = r1 ^ r2; w_upd_zn = 1'b1; end
            OP_NOT: begin w_res = ~r1;     w_upd_zn = 1'b1; end
            OP_ADD, OP_ADDC: begin
                w_res     = w_sum[WIDTH-1:0];
                w_flg[FC] = w_sum[WIDTH];
                w_flg[FF] = (r1[MSB] == r2[MSB]) && (w_sum[MSB] != r1[MSB]);
                w_upd_zn  = 1'b1;
            end
            OP_ADDU: begin
                w_res     = w_sum[WIDTH-1:0];
                w_flg[FC] = w_sum[WIDTH];
                w_flg[FZ] = (w_sum[WIDTH-1:0] == '0);
            end
            OP_SUB, OP_SUBC: begin
                w_res     = w_dif[WIDTH-1:0];
                w_flg[FC] = w_dif[WIDTH];
                w_flg[FF] = (r1[MSB] != r2[MSB]) && (w_dif[MSB] != r1[MSB]);
                w_upd_zn  = 1'b1;
            end
            OP_CMP: begin
                w_res     = '0;
                w_flg[FL] = (r1 < r2);
                w_flg[FN] = ($signed(r1) < $signed(r2));
                w_flg[FZ] = (r1 == r2);
            end
            OP_RSH: begin
                w_res    = w_big ? '0 : (r1 >> w_amt);
                w_upd_zn = 1'b1;
            end
            OP_LSH: begin
                w_res    = w_big ? '0 : (r1 << w_amt);
                w_upd_zn = 1'b1;
            end
            OP_ALSH: begin
                w_res     = w_big ? '0 : (r1 << w_amt);
                w_flg[FF] = w_alsh_f;
                w_upd_zn  = 1'b1;
            end
            OP_ARSH: begin
                w_res    = w_big ? {WIDTH{r1[MSB]}} : WIDTH'($signed(r1) >>> w_amt);
                w_upd_zn = 1'b1;
            end
`ifdef ALU_MUL_EN
            OP_MUL: w_is_mul = 1'b1;
`endif
            default: begin
                w_res = '0;
                w_err = 1'b1;
            end
        endcase

        if (w_upd_zn) begin
            w_flg[FZ] = (w_res == '0);
            w_flg[FN] = w_res[MSB];
        end
    end

    // State register
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
`ifdef ALU_MUL_EN
                    w_state_nxt = w_is_mul ? S_BUSY : S_DONE;
`else
                    w_state_nxt = S_DONE;
`endif
                end
            end
`ifdef ALU_MUL_EN
            S_BUSY: begin
                if (w_mul_last) w_state_nxt = S_DONE;
            end
`endif
            S_DONE: begin
                if (out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Result, flag and multiplier registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_rout    <= '0;
            r_flags   <= '0;
            r_err     <= 1'b0;
`ifdef ALU_MUL_EN
            r_rout_hi <= '0;
            r_mcand   <= '0;
            r_ph      <= '0;
            r_pl      <= '0;
            r_cnt     <= '0;
`endif
        end else begin
            if ((r_state == S_IDLE) && w_accept) begin
`ifdef ALU_MUL_EN
                if (w_is_mul) begin
                    r_mcand <= r1;
                    r_pl    <= r2;
                    r_ph    <= '0;
                    r_cnt   <= '0;
                end else begin
                    r_rout    <= w_res;
                    r_rout_hi <= '0;
                    r_flags   <= w_flg;
                    r_err     <= w_err;
                end
`else
                r_rout  <= w_res;
                r_flags <= w_flg;
                r_err   <= w_err;
`endif
            end
`ifdef ALU_MUL_EN
            // WIDTH shift-add steps, then one cycle to publish the product
            if (r_state == S_BUSY) begin
                if (w_mul_last) begin
                    r_rout      <= r_pl;
                    r_rout_hi   <= r_ph;
                    r_flags[FZ] <= ~|{r_ph, r_pl};
                    r_flags[FC] <= |r_ph;
                    r_err       <= 1'b0;
                end else begin
                    r_ph  <= w_step[WIDTH:1];
                    r_pl  <= {w_step[0], r_pl[WIDTH-1:1]};
                    r_cnt <= r_cnt + 1'b1;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed test-plan vectors, multiplier,
// reset abort, randomized traffic and back-to-back operations, compared
// against an arithmetic reference model of the opcode rules.
module tb_alu_seq;

    localparam int W = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    opcode;
    logic [W-1:0]  r1;
    logic [W-1:0]  r2;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  rout;
    logic [W-1:0]  rout_hi;
    logic [4:0]    flags;
    logic          err;

    int            n_vec = 0;
    int            n_err = 0;
    logic [4:0]    m_flags;

`ifdef ALU_MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif

    always #5 clock = ~clock;

    alu_seq #(.WIDTH(W)) dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .opcode   (opcode),
        .r1       (r1),
        .r2       (r2),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .rout     (rout),
        .rout_hi  (rout_hi),
        .flags    (flags),
        .err      (err)
    );

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d miscompares=%0d", n_vec, n_err);
        $fatal(1);
    end

    // Reference model: plain integer arithmetic over the opcode rules; updates m_flags
    task automatic model(input logic [7:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] e_lo, output logic [W-1:0] e_hi,
                         output logic e_err, output int e_lat);
        longint ua, ub, sa, sb, t, st, full, half, v;
        logic c, l, f, z, n, cin, prev, cur;
        logic [W-1:0] res;
        int k;
        full = longint'(1) << W;
        half = full / 2;
        ua = longint'(a);
        ub = longint'(b);
        sa = (ua >= half) ? ua - full : ua;
        sb = (ub >= half) ? ub - full : ub;
        {c, l, f, z, n} = m_flags;
        cin   = (op == 8'h07 || op == 8'h0A) ? c : 1'b0;
        res   = '0;
        e_hi  = '0;
        e_err = 1'b0;
        e_lat = 1;
        case (op)
            8'h01, 8'h02, 8'h03, 8'h04: begin
                if (op == 8'h01) res = a & b;
                else if (op == 8'h02) res = a | b;
                else if (op == 8'h03) res = a ^ b;
                else res = ~a;
                z = (res == 0); n = res[W-1];
            end
            8'h05, 8'h06, 8'h07: begin
                t  = ua + ub + longint'(cin);
                st = sa + sb + longint'(cin);
                res = W'(t);
                c = (t >= full);
                z = (res == 0);
                if (op != 8'h06) begin
                    f = (st > half - 1) || (st < -half);
                    n = res[W-1];
                end
            end
            8'h09, 8'h0A: begin
                t  = ua - ub - longint'(cin);
                st = sa - sb - longint'(cin);
                res = W'(t);
                c = (t < 0);
                f = (st > half - 1) || (st < -half);
                z = (res == 0); n = res[W-1];
            end
            8'h0B: begin
                res = '0;
                l = (ua < ub); n = (sa < sb); z = (ua == ub);
            end
            8'h08: begin
                res = (ub >= W) ? '0 : W'(ua >> ub);
                z = (res == 0); n = res[W-1];
            end
            8'h0C, 8'h0D: begin
                res = (ub >= W) ? '0 : W'(ua << ub);
                if (op == 8'h0C) begin
                    k = (ub >= W) ? W : int'(ub);
                    v = ua;
                    f = 1'b0;
                    for (int i = 0; i < k; i++) begin
                        prev = ((v >> (W - 1)) & 1) != 0;
                        v = (v << 1) % full;
                        cur = ((v >> (W - 1)) & 1) != 0;
                        if (cur != prev) f = 1'b1;
                    end
                end
                z = (res == 0); n = res[W-1];
            end
            8'h0F: begin
                if (ub >= W) res = (sa < 0) ? '1 : '0;
                else res = W'(sa >>> ub);
                z = (res == 0); n = res[W-1];
            end
            8'h0E: begin
                if (MUL_ON) begin
                    t = ua * ub;
                    res = W'(t);
                    e_hi = W'(t >> W);
                    z = (t == 0);
                    c = ((t >> W) != 0);
                    e_lat = W + 1;
                end else begin
                    e_err = 1'b1;
                end
            end
            default: e_err = 1'b1;
        endcase
        e_lo = res;
        m_flags = {c, l, f, z, n};
    endtask

    // Drives one operation through the handshake and returns what the DUT showed;
    // lat==0 means no result appeared within the cycle budget.
    task automatic issue(input logic [7:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int stall, output int lat,
                         output logic [W-1:0] g_lo, output logic [W-1:0] g_hi,
                         output logic [4:0] g_fl, output logic g_err, output bit stable);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clock); #1; guard++;
        end
        opcode = op; r1 = a; r2 = b; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        opcode = 8'($urandom); r1 = W'($urandom); r2 = W'($urandom);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clock); #1; lat++;
        end
        if (!out_valid) lat = 0;
        g_lo = rout; g_hi = rout_hi; g_fl = flags; g_err = err;
        stable = 1'b1;
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'b1;
            @(posedge clock); #1;
            if (rout !== g_lo || rout_hi !== g_hi || flags !== g_fl || err !== g_err ||
                out_valid !== 1'b1 || in_ready !== 1'b0)
                stable = 1'b0;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        opcode = '0; r1 = '0; r2 = '0;
        repeat (3) @(posedge clock);
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset out_valid: got %b exp 0", out_valid); end
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset in_ready: got %b exp 0", in_ready); end
        n_vec++; if ({rout, rout_hi} !== '0) begin n_err++; $display("FAIL reset rout/rout_hi: got %h/%h exp 0/0", rout, rout_hi); end
        n_vec++; if (flags !== 5'b0) begin n_err++; $display("FAIL reset flags: got %b exp 00000", flags); end
        n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL reset err: got %b exp 0", err); end
        reset = 1'b1;
        m_flags = '0;
        @(posedge clock); #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL idle in_ready: got %b exp 1", in_ready); end
    endtask

    // Hand-computed vectors applied in order; flags chain from one op to the next
    task automatic test_directed();
        logic [7:0]   t_op [15] = '{8'h05, 8'h05, 8'h07, 8'h09, 8'h0B, 8'h0F, 8'h0D, 8'h08,
                                    8'h0C, 8'h0F, 8'h08, 8'h0A, 8'h55, 8'h04, 8'h03};
        logic [W-1:0] t_a  [15] = '{16'h7FFF, 16'hFFFF, 16'h0001, 16'h0001, 16'hFFFF, 16'h8000,
                                    16'h0001, 16'h8000, 16'h4000, 16'h8000, 16'h8000, 16'h0000,
                                    16'h0001, 16'h00FF, 16'hF0F0};
        logic [W-1:0] t_b  [15] = '{16'h0001, 16'h0001, 16'h0001, 16'h0002, 16'h0002, 16'd20,
                                    16'd15, 16'd16, 16'd1, 16'd15, 16'd15, 16'hFFFF,
                                    16'h0002, 16'h0000, 16'hFF00};
        logic [W-1:0] x_lo [15] = '{16'h8000, 16'h0000, 16'h0003, 16'hFFFF, 16'h0000, 16'hFFFF,
                                    16'h8000, 16'h0000, 16'h8000, 16'hFFFF, 16'h0001, 16'h0000,
                                    16'h0000, 16'hFF00, 16'h0FF0};
        logic [4:0]   x_fl [15] = '{5'h05, 5'h12, 5'h00, 5'h11, 5'h11, 5'h11, 5'h11, 5'h12,
                                    5'h15, 5'h15, 5'h14, 5'h12, 5'h12, 5'h11, 5'h10};
        logic [W-1:0] g_lo, g_hi, e_lo, e_hi;
        logic [4:0]   g_fl;
        logic         g_err, e_err;
        int           lat, e_lat;
        bit           stable;
        for (int i = 0; i < 15; i++) begin
            model(t_op[i], t_a[i], t_b[i], e_lo, e_hi, e_err, e_lat);
            issue(t_op[i], t_a[i], t_b[i], 1, lat, g_lo, g_hi, g_fl, g_err, stable);
            n_vec++; if (g_lo !== x_lo[i]) begin n_err++; $display("FAIL dir[%0d] op %h rout: got %h exp %h", i, t_op[i], g_lo, x_lo[i]); end
            n_vec++; if (g_fl !== x_fl[i]) begin n_err++; $display("FAIL dir[%0d] op %h flags: got %b exp %b", i, t_op[i], g_fl, x_fl[i]); end
            n_vec++; if (g_err !== (t_op[i] == 8'h55)) begin n_err++; $display("FAIL dir[%0d] op %h err: got %b", i, t_op[i], g_err); end
            n_vec++; if (g_hi !== '0) begin n_err++; $display("FAIL dir[%0d] op %h rout_hi: got %h exp 0", i, t_op[i], g_hi); end
            n_vec++; if (lat !== 1) begin n_err++; $display("FAIL dir[%0d] op %h latency: got %0d exp 1", i, t_op[i], lat); end
            n_vec++; if (stable !== 1'b1) begin n_err++; $display("FAIL dir[%0d] op %h hold: outputs moved or in_ready high while stalled", i, t_op[i]); end
        end
    endtask

    task automatic test_mul();
        logic [W-1:0] g_lo, g_hi, e_lo, e_hi;
        logic [4:0]   g_fl;
        logic         g_err, e_err;
        int           lat, e_lat;
        bit           stable;
        logic [W-1:0] m_a [3] = '{16'd300, 16'hFFFF, 16'h0000};
        logic [W-1:0] m_b [3] = '{16'd300, 16'hFFFF, 16'h1234};
`ifdef ALU_MUL_EN
        logic [W-1:0] x_lo [3] = '{16'h5F90, 16'h0001, 16'h0000};
        logic [W-1:0] x_hi [3] = '{16'h0001, 16'hFFFE, 16'h0000};
        logic         x_c  [3] = '{1'b1, 1'b1, 1'b0};
        logic         x_z  [3] = '{1'b0, 1'b0, 1'b1};
`endif
        for (int i = 0; i < 3; i++) begin
            model(8'h0E, m_a[i], m_b[i], e_lo, e_hi, e_err, e_lat);
            issue(8'h0E, m_a[i], m_b[i], 5, lat, g_lo, g_hi, g_fl, g_err, stable);
            n_vec++; if (g_fl !== m_flags) begin n_err++; $display("FAIL mul[%0d] flags: got %b exp %b", i, g_fl, m_flags); end
            n_vec++; if (stable !== 1'b1) begin n_err++; $display("FAIL mul[%0d] hold: outputs moved or in_ready high during 5-cycle stall", i); end
`ifdef ALU_MUL_EN
            n_vec++; if (g_lo !== x_lo[i]) begin n_err++; $display("FAIL mul[%0d] rout: got %h exp %h", i, g_lo, x_lo[i]); end
            n_vec++; if (g_hi !== x_hi[i]) begin n_err++; $display("FAIL mul[%0d] rout_hi: got %h exp %h", i, g_hi, x_hi[i]); end
            n_vec++; if (g_fl[4] !== x_c[i] || g_fl[1] !== x_z[i]) begin n_err++; $display("FAIL mul[%0d] C/Z: got %b/%b exp %b/%b", i, g_fl[4], g_fl[1], x_c[i], x_z[i]); end
            n_vec++; if (g_err !== 1'b0) begin n_err++; $display("FAIL mul[%0d] err: got %b exp 0", i, g_err); end
            n_vec++; if (lat !== W + 1) begin n_err++; $display("FAIL mul[%0d] latency: got %0d exp %0d", i, lat, W + 1); end
`else
            n_vec++; if (g_lo !== '0 || g_hi !== '0) begin n_err++; $display("FAIL mul-off[%0d] rout/rout_hi: got %h/%h exp 0/0", i, g_lo, g_hi); end
            n_vec++; if (g_err !== 1'b1) begin n_err++; $display("FAIL mul-off[%0d] err: got %b exp 1", i, g_err); end
            n_vec++; if (lat !== 1) begin n_err++; $display("FAIL mul-off[%0d] latency: got %0d exp 1", i, lat); end
`endif
        end
    endtask

    // Accept an op, assert reset part way through, then check an illegal opcode
    task automatic test_reset_abort();
        logic [W-1:0] g_lo, g_hi, e_lo, e_hi;
        logic [4:0]   g_fl;
        logic         g_err, e_err;
        int           lat, e_lat;
        bit           stable;
        model(8'h05, 16'hFFFF, 16'h0001, e_lo, e_hi, e_err, e_lat);
        issue(8'h05, 16'hFFFF, 16'h0001, 0, lat, g_lo, g_hi, g_fl, g_err, stable);
        n_vec++; if (flags !== m_flags) begin n_err++; $display("FAIL abort-setup flags: got %b exp %b", flags, m_flags); end
        opcode = MUL_ON ? 8'h0E : 8'h05; r1 = 16'd1234; r2 = 16'd567; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (7) begin @(posedge clock); #1; end
        reset = 1'b0;
        @(posedge clock); #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL abort out_valid: got %b exp 0", out_valid); end
        n_vec++; if (flags !== 5'b0) begin n_err++; $display("FAIL abort flags: got %b exp 00000", flags); end
        n_vec++; if (rout !== '0 || rout_hi !== '0 || err !== 1'b0) begin n_err++; $display("FAIL abort outputs: rout %h rout_hi %h err %b exp 0", rout, rout_hi, err); end
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL abort in_ready: got %b exp 0", in_ready); end
        reset = 1'b1;
        m_flags = '0;
        @(posedge clock); #1;
        model(8'h55, 16'hABCD, 16'h1234, e_lo, e_hi, e_err, e_lat);
        issue(8'h55, 16'hABCD, 16'h1234, 2, lat, g_lo, g_hi, g_fl, g_err, stable);
        n_vec++; if (g_err !== 1'b1 || g_lo !== '0) begin n_err++; $display("FAIL illegal: err %b rout %h exp 1/0000", g_err, g_lo); end
        n_vec++; if (g_fl !== 5'b0 || lat !== 1) begin n_err++; $display("FAIL illegal flags/latency: got %b/%0d exp 00000/1", g_fl, lat); end
    endtask

    task automatic test_random(input int count, input int max_stall, input bit b2b);
        logic [W-1:0] g_lo, g_hi, e_lo, e_hi, a, b;
        logic [4:0]   g_fl;
        logic [7:0]   op;
        logic         g_err, e_err;
        int           lat, e_lat;
        bit           stable;
        for (int i = 0; i < count; i++) begin
            op = ($urandom_range(0, 9) < 8) ? 8'($urandom_range(1, 15)) : 8'($urandom);
            a  = W'($urandom);
            b  = ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, W + 4)) : W'($urandom);
            case ($urandom_range(0, 7))
                0: a = '0;
                1: a = '1;
                2: a = 16'h8000;
                default: ;
            endcase
            model(op, a, b, e_lo, e_hi, e_err, e_lat);
            issue(op, a, b, $urandom_range(0, max_stall), lat, g_lo, g_hi, g_fl, g_err, stable);
            n_vec++; if (g_lo !== e_lo || g_hi !== e_hi) begin n_err++; $display("FAIL rand[%0d] op %h a %h b %h result: got %h_%h exp %h_%h", i, op, a, b, g_hi, g_lo, e_hi, e_lo); end
            n_vec++; if (g_fl !== m_flags) begin n_err++; $display("FAIL rand[%0d] op %h a %h b %h flags: got %b exp %b", i, op, a, b, g_fl, m_flags); end
            n_vec++; if (g_err !== e_err) begin n_err++; $display("FAIL rand[%0d] op %h err: got %b exp %b", i, op, g_err, e_err); end
            n_vec++; if (lat !== e_lat) begin n_err++; $display("FAIL rand[%0d] op %h latency: got %0d exp %0d", i, op, lat, e_lat); end
            n_vec++; if (stable !== 1'b1) begin n_err++; $display("FAIL rand[%0d] op %h hold: outputs moved while stalled", i, op); end
            if (b2b) begin
                n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL b2b[%0d] drain: out_valid %b in_ready %b exp 0/1", i, out_valid, in_ready); end
            end
        end
    endtask

    task automatic test_back_to_back();
        test_random(40, 0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_mul();
        test_reset_abort();
        test_random(150, 3, 1'b0);
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
